card_display_scan: RTL

- Downstream consumer of the card-billing stage's `dispmoney`, `disptime`, `read`, `warn` and `cut` outputs.
- Drives a six-digit, time-multiplexed, common-cathode 7-segment display: three money digits and three call-time digits.
- Snapshots all inputs once per scan frame so a frame never shows a torn value.
- Adds leading-zero blanking, money blinking during warn, a dash display during cut, and a blank display when no card is present.

---
 rtl/card_display_scan_if.sv | 30 +++
 rtl/card_display_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/card_display_scan_if.sv
// Bundle between the card-billing stage and the display scanner.
//   dispmoney : money balance, [10:8] hundreds, [7:4] tens BCD, [3:0] units BCD
//   disptime  : call time, [8] hundreds, [7:4] tens BCD, [3:0] units BCD
//   read      : card present
//   warn      : low-balance warning
//   cut       : call cut
//   seg       : segments a..g on bits 0..6, active-high
//   dig       : one-hot digit select, bit0 = leftmost digit
//   frame     : one-cycle pulse when the scanner takes a snapshot
// master = the side that supplies the billing values, slave = the scanner.
interface card_display_scan_if;
   logic [10:0] dispmoney;
   logic [8:0]  disptime;
   logic        read;
   logic        warn;
   logic        cut;
   logic [6:0]  seg;
   logic [5:0]  dig;
   logic        frame;

   modport master (
      output dispmoney, disptime, read, warn, cut,
      input  seg, dig, frame
   );

   modport slave (
      input  dispmoney, disptime, read, warn, cut,
      output seg, dig, frame
   );
endinterface

// File: rtl/card_display_scan.sv
// Six-digit time-multiplexed 7-segment scanner for the card-billing display.
// Digits 0..2 show money (hundreds, tens, units), digits 3..5 show call time.
// All billing inputs are captured once per scan frame so a frame is never torn.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : card_display_scan_if.slave (billing inputs in, seg/dig/frame out)
// Parameters:
//   SCAN_DIV     : cycles each digit stays selected (2..65535)
//   BLINK_FRAMES : frames per blink half-period while warn is set (1..255)
//   LZB          : 1 blanks leading zeros in each group, 0 shows every digit
module card_display_scan #(
   parameter int SCAN_DIV     = 4,
   parameter int BLINK_FRAMES = 8,
   parameter int LZB          = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   card_display_scan_if.slave   bus
);

   logic [15:0] div;
   logic [2:0]  idx;
   logic [7:0]  blink_cnt;
   logic        blink_on;

   logic [10:0] snap_money;
   logic [8:0]  snap_time;
   logic        snap_read;
   logic        snap_warn;
   logic        snap_cut;

   logic        div_end;
   logic        snap_now;
   logic [3:0]  nib;
   logic        lead_blank;
   logic [6:0]  seg_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h79;
      endcase
      return s;
   endfunction

   assign div_end  = (div == 16'(SCAN_DIV - 1));
   // The last digit slot of a frame doubles as the snapshot instant.
   assign snap_now = div_end && (idx == 3'd5);

   // Select the nibble for the current digit and whether it is a leading zero
   // within its group (units are never blanked).
   always_comb begin
      nib        = 4'd0;
      lead_blank = 1'b0;
      case (idx)
         3'd0: begin
            nib        = {1'b0, snap_money[10:8]};
            lead_blank = (snap_money[10:8] == 3'd0);
         end
         3'd1: begin
            nib        = snap_money[7:4];
            lead_blank = (snap_money[10:8] == 3'd0) && (snap_money[7:4] == 4'd0);
         end
         3'd2: nib = snap_money[3:0];
         3'd3: begin
            nib        = {3'b000, snap_time[8]};
            lead_blank = !snap_time[8];
         end
         3'd4: begin
            nib        = snap_time[7:4];
            lead_blank = !snap_time[8] && (snap_time[7:4] == 4'd0);
         end
         3'd5: nib = snap_time[3:0];
         default: begin
            nib        = 4'd0;
            lead_blank = 1'b0;
         end
      endcase
   end

   // Display priority: no card, cut dash, money blink, error glyph, blanking, digit.
   always_comb begin
      seg_next = decode(nib);
      if (!snap_read)
         seg_next = 7'h00;
      else if (snap_cut)
         seg_next = 7'h40;
      else if (snap_warn && !blink_on && (idx < 3'd3))
         seg_next = 7'h00;
      else if (nib > 4'd9)
         seg_next = 7'h79;
      else if ((LZB != 0) && lead_blank)
         seg_next = 7'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div        <= 16'd0;
         idx        <= 3'd0;
         blink_cnt  <= 8'd0;
         blink_on   <= 1'b1;
         snap_money <= 11'd0;
         snap_time  <= 9'd0;
         snap_read  <= 1'b0;
         snap_warn  <= 1'b0;
         snap_cut   <= 1'b0;
         bus.seg    <= 7'h00;
         bus.dig    <= 6'b000000;
         bus.frame  <= 1'b0;
      end else begin
         div <= div_end ? 16'd0 : div + 16'd1;
         if (div_end)
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;

         if (snap_now) begin
            snap_money <= bus.dispmoney;
            snap_time  <= bus.disptime;
            snap_read  <= bus.read;
            snap_warn  <= bus.warn;
            snap_cut   <= bus.cut;
            // Blink phase advances every frame even without warn, so the
            // first dark half appears at a fixed point in the frame sequence.
            if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
               blink_cnt <= 8'd0;
               blink_on  <= !blink_on;
            end else begin
               blink_cnt <= blink_cnt + 8'd1;
            end
         end

         // Output stage: one cycle behind idx.
         bus.frame <= snap_now;
         bus.dig   <= 6'b000001 << idx;
         bus.seg   <= seg_next;
      end
   end

endmodule
